// File: rtl/sipo_word_assembler_if.sv
// sipo_word_assembler_if
//   Bundles the serial-in and word-out signals of the SIPO word assembler.
//   slave  : the assembler (consumes bits, produces words).
//   master : the environment (drives bits and flow control, observes words).
// Signals:
//   bit_in, bit_en : serial data bit and its sample strobe.
//   clear          : synchronous flush of assembly and output state.
//   word_out       : last completed word, stable while word_valid=1.
//   word_valid     : word_out holds an unconsumed word.
//   word_ready     : consumer accepts word_out on an edge with word_valid=1.
//   bit_count      : bits currently in the shift register, 0..WIDTH-1.
//   overrun        : sticky flag, a completed word was dropped.
interface sipo_word_assembler_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned CntW = $clog2(WIDTH);

  logic             bit_in;
  logic             bit_en;
  logic             clear;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
  logic [CntW-1:0]  bit_count;
  logic             overrun;

  modport slave (
    input  bit_in,
    input  bit_en,
    input  clear,
    input  word_ready,
    output word_out,
    output word_valid,
    output bit_count,
    output overrun
  );

  modport master (
    output bit_in,
    output bit_en,
    output clear,
    output word_ready,
    input  word_out,
    input  word_valid,
    input  bit_count,
    input  overrun
  );
endinterface

// File: rtl/sipo_word_assembler.sv
// sipo_word_assembler
//   Collects the held bit of the upstream latch stage, one bit per strobed edge, into
//   WIDTH-bit words. Each completed word is handed to a one-entry valid/ready output
//   register on the very edge it completes; a word completing while the previous one is
//   still unconsumed is dropped and flagged with the sticky overrun bit. Assembly of the
//   next word always proceeds in parallel with the held output word.
// Parameters:
//   WIDTH     : bits per word (at least 2).
//   MSB_FIRST : 1 -> first received bit ends up in word_out[WIDTH-1],
//               0 -> first received bit ends up in word_out[0].
// Ports:
//   clk   : clock, rising edge active.
//   rst_n : asynchronous active-low reset.
//   bus   : slave side of sipo_word_assembler_if (serial input, word output, status).
// All outputs come straight from flops; no input reaches an output combinationally.
module sipo_word_assembler #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sipo_word_assembler_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastIdx = CntW'(WIDTH - 1);

  typedef enum logic [0:0] {
    StEmpty,
    StValid
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  cnt_q,   cnt_d;
  logic [WIDTH-1:0] word_q,  word_d;
  logic             overrun_q, overrun_d;

  // Shift register value including the bit presented on this edge. On a completing
  // edge this is exactly the finished word, which is what allows the zero-latency load.
  logic [WIDTH-1:0] shift_val;
  logic             complete;

  if (MSB_FIRST) begin : g_msb_first
    assign shift_val = {shreg_q[WIDTH-2:0], bus.bit_in};
    // The oldest bit falls off the top; it has already been captured if it belonged to
    // a completed word.
    logic unused_shreg_bit;
    assign unused_shreg_bit = shreg_q[WIDTH-1];
  end else begin : g_lsb_first
    assign shift_val = {bus.bit_in, shreg_q[WIDTH-1:1]};
    logic unused_shreg_bit;
    assign unused_shreg_bit = shreg_q[0];
  end

  assign complete = bus.bit_en && (cnt_q == LastIdx);

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    overrun_d = overrun_q;

    if (bus.clear) begin
      // Flush wins over any strobe or handshake on this edge; word_out is left alone.
      state_d   = StEmpty;
      shreg_d   = '0;
      cnt_d     = '0;
      overrun_d = 1'b0;
    end else begin
      if (bus.bit_en) begin
        shreg_d = shift_val;
        cnt_d   = complete ? '0 : cnt_q + CntW'(1);
      end

      unique case (state_q)
        StEmpty: begin
          if (complete) begin
            word_d  = shift_val;
            state_d = StValid;
          end
        end
        StValid: begin
          if (complete) begin
            if (bus.word_ready) begin
              // Consumer takes the old word as the new one arrives: swap in place.
              word_d = shift_val;
            end else begin
              overrun_d = 1'b1;
            end
          end else if (bus.word_ready) begin
            state_d = StEmpty;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StEmpty;
      shreg_q   <= '0;
      cnt_q     <= '0;
      word_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      word_q    <= word_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.word_out   = word_q;
  assign bus.word_valid = (state_q == StValid);
  assign bus.bit_count  = cnt_q;
  assign bus.overrun    = overrun_q;

  // A held word may only change when the consumer is taking it.
  word_stable_a : assert property (@(posedge clk) disable iff (!rst_n)
    (bus.word_valid && !bus.word_ready) |=> $stable(bus.word_out));

  bit_count_range_a : assert property (@(posedge clk) disable iff (!rst_n)
    cnt_q <= LastIdx);

endmodule
